// File: rtl/seu_window_controller_pkg.sv
// seu_window_controller_pkg: shared SEU test FSM encoding, settle length and default sizes
package seu_window_controller_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, BASE, RUN, SNAP} state_t;
  localparam int SETTLE_LEN = 2;
  localparam int NCH_DEF = 7;
  localparam int CNT_W_DEF = 64;
  localparam int WIN_W_DEF = 32;
  function automatic int sel_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/seu_snapshot_bank.sv
// seu_snapshot_bank: per-channel baseline capture, wrapping delta snapshot and registered readout
module seu_snapshot_bank #(
  parameter int NCH = 7,
  parameter int CNT_W = 64,
  parameter int SEL_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 capture,
  input  logic                 commit,
  input  logic                 zero,
  input  logic [NCH*CNT_W-1:0] err_count,
  input  logic                 rd_req,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic                 rd_ack,
  output logic [CNT_W-1:0]     rd_data
);
  logic [CNT_W-1:0] base_q [NCH];
  logic [CNT_W-1:0] snap_q [NCH];
  logic [CNT_W-1:0] rd_mux;
  // baselines latch in BASE; snapshots commit in SNAP, forced to zero when no baseline was taken
  always_ff @(posedge clock)
    for (int k = 0; k < NCH; k++)
      if (reset) begin
        base_q[k] <= '0;
        snap_q[k] <= '0;
      end else begin
        if (capture) base_q[k] <= err_count[k*CNT_W +: CNT_W];
        if (commit) snap_q[k] <= zero ? '0 : err_count[k*CNT_W +: CNT_W] - base_q[k];
      end
  // channel select; out-of-range selects fall through to zero
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NCH; k++) if (rd_sel == SEL_W'(k)) rd_mux = snap_q[k];
  end
  // one-cycle registered readout, data held between requests
  always_ff @(posedge clock) begin
    rd_ack <= reset ? 1'b0 : rd_req;
    rd_data <= reset ? '0 : rd_req ? rd_mux : rd_data;
  end
endmodule

// File: rtl/seu_window_controller.sv
// seu_window_controller: sequences clear/settle/baseline/run/snapshot windows over PRBS31 checker counts
module seu_window_controller
  import seu_window_controller_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  localparam int SEL_W = sel_w(NCH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 continuous,
  input  logic [WIN_W-1:0]     window_len,
  input  logic [NCH*CNT_W-1:0] err_count,
  output logic [NCH-1:0]       clear_pulse,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [15:0]          window_id,
  input  logic                 rd_req,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic                 rd_ack,
  output logic [CNT_W-1:0]     rd_data
);
  state_t state_q, state_d;
  logic [WIN_W-1:0] len_q, cnt_q;
  logic [1:0] settle_q;
  logic abort_q, zero_q;
  // state register
  always_ff @(posedge clock) state_q <= reset ? IDLE : state_d;
  // next state and Moore outputs; stop from any pre-SNAP busy state goes straight to SNAP
  always_comb begin
    state_d = state_q;
    busy = state_q != IDLE;
    done = state_q == SNAP;
    clear_pulse = {NCH{reset || state_q == CLEAR}};
    case (state_q)
      IDLE:    state_d = start ? CLEAR : IDLE;
      CLEAR:   state_d = stop ? SNAP : SETTLE;
      SETTLE:  state_d = stop ? SNAP : settle_q == 2'(SETTLE_LEN - 1) ? BASE : SETTLE;
      BASE:    state_d = stop ? SNAP : RUN;
      RUN:     state_d = stop || cnt_q == WIN_W'(1) ? SNAP : RUN;
      SNAP:    state_d = continuous && !abort_q ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // window bookkeeping: length latch, settle/run counters, abort tracking and commit status
  always_ff @(posedge clock)
    if (reset) begin
      len_q <= WIN_W'(1);
      cnt_q <= '0;
      settle_q <= '0;
      abort_q <= 1'b0;
      zero_q <= 1'b0;
      aborted <= 1'b0;
      window_id <= '0;
    end else begin
      if (state_q == IDLE && start) len_q <= window_len == '0 ? WIN_W'(1) : window_len;
      settle_q <= state_q == SETTLE ? settle_q + 2'd1 : '0;
      cnt_q <= state_q == BASE ? len_q : state_q == RUN ? cnt_q - WIN_W'(1) : cnt_q;
      if (stop && busy && !done) begin
        abort_q <= 1'b1;
        zero_q <= state_q != RUN;
      end
      if (done) begin
        abort_q <= 1'b0;
        zero_q <= 1'b0;
        aborted <= abort_q;
        window_id <= window_id + 16'd1;
      end
    end
  seu_snapshot_bank #(.NCH(NCH), .CNT_W(CNT_W), .SEL_W(SEL_W)) u_bank (
    .clock(clock),
    .reset(reset),
    .capture(state_q == BASE),
    .commit(done),
    .zero(zero_q),
    .err_count(err_count),
    .rd_req(rd_req),
    .rd_sel(rd_sel),
    .rd_ack(rd_ack),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_seu_window_controller.sv
// tb_seu_window_controller: scoreboard bench for window timing, snapshots, abort and readout
module tb_seu_window_controller;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, continuous = 1'b0, rd_req = 1'b0;
  logic [31:0] window_len = '0;
  logic [447:0] err_count;
  logic [2:0] rd_sel = '0;
  logic [6:0] clear_pulse;
  logic busy, done, aborted, rd_ack;
  logic [15:0] window_id;
  logic [63:0] rd_data;
  logic [63:0] cnt [7], base [7], inc [7], snap [7];
  typedef struct { int cyc; logic ab; logic [15:0] id; } win_t;
  typedef struct { int cyc; logic [63:0] d; } rd_t;
  win_t win_q[$];
  rd_t rd_q[$];
  win_t pend;
  int cyc = 0, checks = 0, errors = 0, clr_n = 0;
  logic chk_id = 1'b0;
  logic [15:0] id_exp = '0;

  seu_window_controller dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .continuous(continuous),
    .window_len(window_len), .err_count(err_count), .clear_pulse(clear_pulse), .busy(busy),
    .done(done), .aborted(aborted), .window_id(window_id), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_ack(rd_ack), .rd_data(rd_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always_comb for (int k = 0; k < 7; k++) err_count[k*64 +: 64] = cnt[k];

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // monitor: pops expected windows on done and expected read data on rd_ack
  always @(negedge clock) begin
    if (reset) begin
      clr_n = 0;
      chk_id = 1'b0;
    end else begin
      if (chk_id) begin
        check("aborted", aborted, pend.ab);
        check("window_id", window_id, pend.id);
        chk_id = 1'b0;
      end
      if (clear_pulse != '0) begin
        check("clear_pulse", clear_pulse, 7'h7f);
        clr_n++;
      end
      if (done) begin
        if (win_q.size() == 0) check("spurious_done", win_q.size(), 1);
        else begin
          pend = win_q.pop_front();
          check("done_cycle", cyc, pend.cyc);
          check("clears_per_window", clr_n, 1);
          clr_n = 0;
          chk_id = 1'b1;
        end
      end
      if (rd_ack) begin
        if (rd_q.size() == 0) check("spurious_rd_ack", rd_q.size(), 1);
        else begin
          rd_t r;
          r = rd_q.pop_front();
          check("rd_cycle", cyc, r.cyc);
          check("rd_data", rd_data, r.d);
        end
      end
    end
  end

  task automatic setup(input logic [63:0] b);
    for (int k = 0; k < 7; k++) begin
      base[k] = b;
      inc[k] = '0;
    end
  endtask

  task automatic drive(input int t, input int lim);
    int n;
    n = t - 5;
    if (n < 0) n = 0;
    if (n > lim) n = lim;
    for (int k = 0; k < 7; k++) cnt[k] = base[k] + inc[k] * 64'(n);
  endtask

  task automatic read(input logic [2:0] sel, input logic [63:0] e);
    rd_t r;
    @(posedge clock); #1;
    rd_req = 1'b1;
    rd_sel = sel;
    r.cyc = cyc + 1;
    r.d = e;
    rd_q.push_back(r);
    @(posedge clock); #1;
    rd_req = 1'b0;
  endtask

  task automatic read_all();
    for (int k = 0; k < 8; k++)
      if (k < 7) read(3'(k), snap[k]);
      else read(3'(k), 64'd0);
  endtask

  // stop_t: -1 none, 0 together with start, >0 offset from the start cycle
  task automatic window(input int len, input int stop_t, input logic cont);
    int le, lim, dt, p;
    win_t w;
    rd_t r;
    le = len == 0 ? 1 : len;
    lim = stop_t <= 0 ? le : (stop_t >= 5 ? stop_t - 4 : 0);
    dt = stop_t > 0 ? stop_t + 1 : le + 5;
    @(posedge clock); #1;
    p = cyc;
    id_exp++;
    w.cyc = p + dt;
    w.ab = stop_t > 0;
    w.id = id_exp;
    win_q.push_back(w);
    start = 1'b1;
    stop = stop_t == 0;
    window_len = len;
    continuous = cont;
    drive(0, lim);
    for (int t = 1; t <= dt; t++) begin
      @(posedge clock); #1;
      start = t == 2;
      stop = t == stop_t;
      drive(t, lim);
      rd_req = t == dt;
      rd_sel = '0;
      if (t == dt) begin
        r.cyc = p + dt + 1;
        r.d = snap[0];
        rd_q.push_back(r);
      end
    end
    @(posedge clock); #1;
    start = 1'b0;
    stop = 1'b0;
    rd_req = 1'b0;
    continuous = 1'b0;
    check("idle_after_window", busy, 1'b0);
    for (int k = 0; k < 7; k++) snap[k] = inc[k] * 64'(lim);
  endtask

  initial begin
    int p;
    win_t w;
    for (int k = 0; k < 7; k++) begin
      cnt[k] = '0;
      base[k] = '0;
      inc[k] = '0;
      snap[k] = '0;
    end
    repeat (2) @(posedge clock);
    #1;
    check("rst_clear_pulse", clear_pulse, 7'h7f);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_aborted", aborted, 1'b0);
    check("rst_window_id", window_id, 16'd0);
    check("rst_rd_ack", rd_ack, 1'b0);
    check("rst_rd_data", rd_data, 64'd0);
    reset = 1'b0;
    setup(64'd5);
    window(10, -1, 1'b0);
    read_all();
    setup(64'd5);
    base[2] = 64'd100;
    inc[2] = 64'd3;
    window(10, 0, 1'b0);
    read_all();
    setup(64'd1000);
    inc[0] = 64'd1;
    window(100, 24, 1'b1);
    read_all();
    setup(64'd7);
    base[1] = 64'hFFFF_FFFF_FFFF_FFFE;
    inc[1] = 64'd4;
    window(1, -1, 1'b0);
    read_all();
    @(posedge clock); #1;
    start = 1'b1;
    window_len = 32'd10;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrst_clear_pulse", clear_pulse, 7'h7f);
    check("midrst_busy", busy, 1'b0);
    check("midrst_window_id", window_id, 16'd0);
    reset = 1'b0;
    id_exp = '0;
    for (int k = 0; k < 7; k++) snap[k] = '0;
    read(3'd1, 64'd0);
    setup(64'd12345);
    inc[3] = 64'd9;
    window(10, 2, 1'b0);
    read_all();
    setup(64'd5);
    @(posedge clock); #1;
    p = cyc;
    start = 1'b1;
    window_len = '0;
    continuous = 1'b1;
    drive(0, 0);
    for (int i = 1; i <= 3; i++) begin
      id_exp++;
      w.cyc = p + 6 * i;
      w.ab = 1'b0;
      w.id = id_exp;
      win_q.push_back(w);
    end
    for (int t = 1; t <= 18; t++) begin
      @(posedge clock); #1;
      start = 1'b0;
      if (t == 13) continuous = 1'b0;
    end
    @(posedge clock); #1;
    check("cont_idle", busy, 1'b0);
    read_all();
    repeat (4) @(posedge clock);
    #1;
    check("win_q_drained", win_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
